instr_fetch: RTL and testbench

Program-counter and fetch sequencer that drives the instruction ROM's address and consumes its 8-bit output. It sits between instROM and the decode/execute stage. It starts a program at a given ROM address and registers each fetched instruction with a valid flag. It resolves relative forward and backward branches reported by execute, squashing the wrong-path fetch, and stops on the halt opcode or on PC overflow.

---
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Program counter and fetch sequencer in front of a combinational instruction ROM.
// Registers each fetched word with a valid flag and resolves relative branches reported by execute.
module instr_fetch #(
    parameter logic [7:0] HALT_OP = 8'b10001000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] start_addr_i,
    output logic [7:0] rom_addr_o,
    input  logic [7:0] rom_data_i,
    output logic [7:0] instr_o,
    output logic       instr_valid_o,
    output logic [7:0] pc_o,
    input  logic       stall_i,
    input  logic       branch_taken_i,
    input  logic       branch_back_i,
    input  logic [7:0] branch_off_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] pc_out_q, pc_out_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [8:0] target_s;

    // Bit 8 of the target is the carry/borrow that flags a branch leaving the address space.
    always_comb begin
        if (branch_back_i) begin
            target_s = {1'b0, pc_out_q} - {1'b0, branch_off_i};
        end else begin
            target_s = {1'b0, pc_out_q} + 9'd1 + {1'b0, branch_off_i};
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        err_d    = err_q;
        case (state_q)
            IDLE, ERROR: begin
                if (start_i) begin
                    pc_d    = start_addr_i;
                    err_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else begin
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                if (stall_i) begin
                    state_d = RUN;
                end else if (valid_q && (instr_q == HALT_OP)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (valid_q && branch_taken_i) begin
                    // The word fetched this cycle is the wrong path; drop it by clearing valid.
                    valid_d = 1'b0;
                    if (target_s[8]) begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end else begin
                        pc_d = target_s[7:0];
                    end
                end else if (valid_q && (pc_out_q == 8'hFF)) begin
                    state_d = ERROR;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    // PC parks at 255 so its word is presented once before the overflow trips.
                    instr_d  = rom_data_i;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    if (pc_q != 8'hFF) begin
                        pc_d = pc_q + 8'd1;
                    end else begin
                        pc_d = pc_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == RUN);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            pc_q     <= 8'd0;
            instr_q  <= 8'd0;
            pc_out_q <= 8'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_out_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small behavioural instruction ROM.
module tb_instr_fetch;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       start_i;
    logic [7:0] start_addr_i;
    logic [7:0] rom_addr_o;
    logic [7:0] rom_data_i;
    logic [7:0] instr_o;
    logic       instr_valid_o;
    logic [7:0] pc_o;
    logic       stall_i;
    logic       branch_taken_i;
    logic       branch_back_i;
    logic [7:0] branch_off_i;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    instr_fetch dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .start_addr_i  (start_addr_i),
        .rom_addr_o    (rom_addr_o),
        .rom_data_i    (rom_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .pc_o          (pc_o),
        .stall_i       (stall_i),
        .branch_taken_i(branch_taken_i),
        .branch_back_i (branch_back_i),
        .branch_off_i  (branch_off_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // Words named in the programs; everything else has bit 7 clear so it never decodes as halt.
    function automatic logic [7:0] rom_word(input logic [7:0] a);
        case (a)
            8'd0:    rom_word = 8'hC1;
            8'd1:    rom_word = 8'h90;
            8'd2:    rom_word = 8'hC2;
            8'd3:    rom_word = 8'h92;
            8'd12:   rom_word = 8'hC1;
            8'd17:   rom_word = 8'hF7;
            8'd26:   rom_word = 8'hC0;
            8'd97:   rom_word = 8'h88;
            8'd98:   rom_word = 8'hC6;
            8'd255:  rom_word = 8'hFF;
            default: rom_word = {1'b0, a[6:0]};
        endcase
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    // Pulse start; returns positioned at T+1.
    task automatic do_start(input logic [7:0] addr);
        start_addr_i = addr;
        start_i      = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] p);
        int n;
        n = 0;
        while (!(instr_valid_o === 1'b1 && pc_o === p) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_pc: pc_o=%0d valid=%b, required valid pc_o=%0d", pc_o, instr_valid_o, p);
        end
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        start_addr_i = 8'd77;
        do_reset();
        start_i = 1'b0;
        checks++;
        if ({rom_addr_o, instr_o, pc_o} !== 24'h0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h instr=%h pc=%h required 00/00/00", rom_addr_o, instr_o, pc_o);
        end
        checks++;
        if ({instr_valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: v/b/d/e=%b required 0000", {instr_valid_o, busy_o, done_o, err_o});
        end
    endtask

    task automatic test_seq_fetch();
        logic [7:0] exp_i [4];
        exp_i = '{8'hC1, 8'h90, 8'hC2, 8'h92};
        do_reset();
        do_start(8'd0);
        checks++;
        if (busy_o !== 1'b1 || rom_addr_o !== 8'd0 || instr_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL start_t1: busy=%b addr=%0d valid=%b required 1/0/0", busy_o, rom_addr_o, instr_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (instr_o !== exp_i[i] || pc_o !== 8'(i) || instr_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch%0d: instr=%h pc=%0d valid=%b required %h/%0d/1",
                         i, instr_o, pc_o, instr_valid_o, exp_i[i], i);
            end
        end
    endtask

    task automatic test_fwd_branch();
        do_reset();
        do_start(8'd0);
        wait_pc(8'd17);
        checks++;
        if (instr_o !== 8'hF7) begin
            errors++;
            $display("FAIL fwd_src: instr=%h required f7", instr_o);
        end
        branch_taken_i = 1'b1;
        branch_back_i  = 1'b0;
        branch_off_i   = 8'd8;
        step();
        branch_taken_i = 1'b0;
        checks++;
        if (instr_valid_o !== 1'b0 || rom_addr_o !== 8'd26) begin
            errors++;
            $display("FAIL fwd_bubble: valid=%b addr=%0d required 0/26", instr_valid_o, rom_addr_o);
        end
        step();
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 8'd26 || instr_o !== 8'hC0) begin
            errors++;
            $display("FAIL fwd_target: valid=%b pc=%0d instr=%h required 1/26/c0", instr_valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_bwd_branch();
        do_reset();
        do_start(8'd0);
        wait_pc(8'd49);
        branch_taken_i = 1'b1;
        branch_back_i  = 1'b1;
        branch_off_i   = 8'd37;
        step();
        branch_taken_i = 1'b0;
        branch_back_i  = 1'b0;
        checks++;
        if (instr_valid_o !== 1'b0 || rom_addr_o !== 8'd12) begin
            errors++;
            $display("FAIL bwd_bubble: valid=%b addr=%0d required 0/12", instr_valid_o, rom_addr_o);
        end
        step();
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 8'd12 || instr_o !== 8'hC1) begin
            errors++;
            $display("FAIL bwd_target: valid=%b pc=%0d instr=%h required 1/12/c1", instr_valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_halt_restart();
        do_reset();
        do_start(8'd93);
        wait_pc(8'd97);
        checks++;
        if (instr_o !== 8'h88) begin
            errors++;
            $display("FAIL halt_word: instr=%h required 88", instr_o);
        end
        step();
        checks++;
        if ({done_o, busy_o, instr_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL halt_h1: done/busy/valid=%b required 100", {done_o, busy_o, instr_valid_o});
        end
        step();
        checks++;
        if ({done_o, busy_o, instr_valid_o} !== 3'b000 || rom_addr_o !== 8'd98) begin
            errors++;
            $display("FAIL halt_h2: done/busy/valid=%b addr=%0d required 000/98",
                     {done_o, busy_o, instr_valid_o}, rom_addr_o);
        end
        do_start(8'd98);
        step();
        checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 8'd98 || instr_o !== 8'hC6) begin
            errors++;
            $display("FAIL restart: valid=%b pc=%0d instr=%h required 1/98/c6", instr_valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        do_start(8'd250);
        wait_pc(8'd255);
        checks++;
        if (instr_o !== 8'hFF || err_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_last: instr=%h err=%b required ff/0", instr_o, err_o);
        end
        step();
        checks++;
        if ({err_o, instr_valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL seq_ovf: err/valid/busy=%b required 100", {err_o, instr_valid_o, busy_o});
        end
        step();
        checks++;
        if ({err_o, instr_valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL err_sticky: err/valid/busy=%b required 100", {err_o, instr_valid_o, busy_o});
        end
        do_start(8'd250);
        checks++;
        if (err_o !== 1'b0 || busy_o !== 1'b1 || rom_addr_o !== 8'd250) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b addr=%0d required 0/1/250", err_o, busy_o, rom_addr_o);
        end
        step();
        branch_taken_i = 1'b1;
        branch_back_i  = 1'b0;
        branch_off_i   = 8'd10;
        step();
        branch_taken_i = 1'b0;
        checks++;
        if ({err_o, instr_valid_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL br_ovf: err/valid/busy=%b required 100", {err_o, instr_valid_o, busy_o});
        end
    endtask

    task automatic test_stall_reset();
        do_reset();
        do_start(8'd0);
        wait_pc(8'd5);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            branch_taken_i = (i == 1);
            branch_off_i   = 8'd40;
            step();
            checks++;
            if (pc_o !== 8'd5 || instr_o !== 8'h05 || instr_valid_o !== 1'b1 || rom_addr_o !== 8'd6) begin
                errors++;
                $display("FAIL stall%0d: pc=%0d instr=%h valid=%b addr=%0d required 5/05/1/6",
                         i, pc_o, instr_o, instr_valid_o, rom_addr_o);
            end
        end
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        step();
        checks++;
        if (pc_o !== 8'd6 || instr_o !== 8'h06 || instr_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: pc=%0d instr=%h valid=%b required 6/06/1", pc_o, instr_o, instr_valid_o);
        end
        wait_pc(8'd20);
        start_i = 1'b1;
        do_reset();
        start_i = 1'b0;
        checks++;
        if ({rom_addr_o, instr_o, pc_o} !== 24'h0 || {instr_valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL midrun_reset: addr=%h instr=%h pc=%h flags=%b required zeros",
                     rom_addr_o, instr_o, pc_o, {instr_valid_o, busy_o, done_o, err_o});
        end
    endtask

    initial begin
        reset_i        = 1'b0;
        start_i        = 1'b0;
        start_addr_i   = 8'd0;
        stall_i        = 1'b0;
        branch_taken_i = 1'b0;
        branch_back_i  = 1'b0;
        branch_off_i   = 8'd0;
        #2;
        test_reset();
        test_seq_fetch();
        test_fwd_branch();
        test_bwd_branch();
        test_halt_restart();
        test_overflow();
        test_stall_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
